// File: rtl/rv_mdu.sv
// rv_mdu: iterative RISC-V M-extension multiply/divide unit, one result bit per cycle.
// Shift-add multiply and restoring divide run on operand magnitudes; the sign is applied on completion.
module rv_mdu #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);
  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   sh_q, sh_d, opnd_q, opnd_d, res_q, res_d;
  logic              is_div_q, is_div_d, sel_q, sel_d, neg_q, neg_d, wop_q, wop_d;

  function automatic logic [XLEN-1:0] fix_w(input logic w, input logic [XLEN-1:0] v);
    fix_w = w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  // Request decode: legality, operand magnitudes and the early-exit divide cases.
  logic            wop, legal, sa_en, sb_en, sa, sb, b_zero, ovf, early;
  logic [XLEN-1:0] mask, min_w, a_w, b_w, ma, mb, early_res;

  always_comb begin
    wop   = op[3];
    legal = !op[3] || ((XLEN == 64) && (op[2] || (op[1:0] == 2'b00)));
    mask  = wop ? XLEN'(32'hFFFF_FFFF) : '1;
    min_w = wop ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    a_w   = a & mask;
    b_w   = b & mask;
    if (op[2]) begin
      sa_en = !op[0];
      sb_en = !op[0];
    end else begin
      sa_en = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
      sb_en = (op[1:0] == 2'b01);
    end
    sa     = sa_en && (wop ? a[31] : a[XLEN-1]);
    sb     = sb_en && (wop ? b[31] : b[XLEN-1]);
    ma     = sa ? ((~a_w + XLEN'(1)) & mask) : a_w;
    mb     = sb ? ((~b_w + XLEN'(1)) & mask) : b_w;
    b_zero = (b_w == '0);
    ovf    = op[2] && !op[0] && (a_w == min_w) && (b_w == mask);
    early  = !legal || (op[2] && (b_zero || ovf));
    if (!legal)      early_res = '0;
    else if (b_zero) early_res = op[1] ? fix_w(wop, a_w) : '1;
    else if (ovf)    early_res = op[1] ? '0 : fix_w(wop, a_w);
    else             early_res = '0;
  end

  // One iteration step plus the signed result it would produce if it is the last one.
  logic [2*XLEN-1:0] mul_acc, prod;
  logic [XLEN:0]     trial, diff;
  logic              qbit;
  logic [XLEN-1:0]   rem, quo, dv, fin;

  always_comb begin
    mul_acc = (acc_q << 1) + (sh_q[XLEN-1] ? {{XLEN{1'b0}}, opnd_q} : '0);
    trial   = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
    diff    = trial - {1'b0, opnd_q};
    qbit    = !diff[XLEN];
    rem     = qbit ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo     = {sh_q[XLEN-2:0], qbit};
    prod    = neg_q ? (~mul_acc + (2*XLEN)'(1)) : mul_acc;
    dv      = sel_q ? rem : quo;
    if (is_div_q) fin = fix_w(wop_q, neg_q ? (~dv + XLEN'(1)) : dv);
    else          fin = sel_q ? prod[2*XLEN-1:XLEN] : fix_w(wop_q, prod[XLEN-1:0]);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    is_div_d = is_div_q;
    sel_d    = sel_q;
    neg_d    = neg_q;
    wop_d    = wop_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          cnt_d    = wop ? CW'(32) : CW'(XLEN);
          is_div_d = op[2];
          sel_d    = op[2] ? op[1] : (op[1:0] != 2'b00);
          neg_d    = (op[2] && op[1]) ? sa : (sa ^ sb);
          wop_d    = wop;
          acc_d    = '0;
          opnd_d   = op[2] ? mb : ma;
          // W-ops are left-aligned so the MSB-first iteration sees bit 31 first.
          sh_d     = (op[2] ? ma : mb) << (wop ? (XLEN - 32) : 0);
          if (early) begin
            res_d   = early_res;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
        BUSY: begin
          acc_d = is_div_q ? {{XLEN{1'b0}}, rem} : mul_acc;
          sh_d  = is_div_q ? quo : (sh_q << 1);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_d   = fin;
            state_d = DONE;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      res_q    <= '0;
      is_div_q <= 1'b0;
      sel_q    <= 1'b0;
      neg_q    <= 1'b0;
      wop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      is_div_q <= is_div_d;
      sel_q    <= sel_d;
      neg_q    <= neg_d;
      wop_q    <= wop_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;

endmodule

// File: tb/tb_rv_mdu.sv
// Scoreboard bench for rv_mdu: directed vectors push expected result and latency; a monitor checks them.
module tb_rv_mdu;
  localparam int unsigned XLEN = 64;
  localparam logic [3:0] MUL = 4'b0000, MULH = 4'b0001, MULHSU = 4'b0010, MULHU = 4'b0011;
  localparam logic [3:0] DIV = 4'b0100, DIVU = 4'b0101, REM = 4'b0110, REMU = 4'b0111;
  localparam logic [3:0] MULW = 4'b1000, DIVW = 4'b1100, DIVUW = 4'b1101, REMW = 4'b1110, REMUW = 4'b1111;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0, rstn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]      op = '0;
  logic [XLEN-1:0] a = '0, b = '0;
  logic            in_ready, out_valid;
  logic [XLEN-1:0] res;

  int tests = 0, fails = 0, cyc = 0;
  bit mon_seen = 1'b0;

  typedef struct { logic [63:0] res; int lat; int acc; string name; } exp_t;
  exp_t sb[$];

  rv_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rstn && out_valid) begin
        if (sb.size() == 0) begin
          if (!mon_seen) check("unexpected_out_valid", 64'(out_valid), 64'd0);
          mon_seen = !out_ready;
        end else begin
          if (!mon_seen) check({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          mon_seen = 1'b1;
          if (out_ready) begin
            check(sb[0].name, res, sb[0].res);
            void'(sb.pop_front());
            mon_seen = 1'b0;
          end
        end
      end
    end
  end

  // Entered and left at posedge+1; the accept edge is the first posedge after in_ready is seen.
  task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int lat, input string name, input bit push);
    int n = 0;
    exp_t e;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
    else if (push) begin
      e.res = exp; e.lat = lat; e.acc = cyc; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'b1011; a = 64'hDEAD_BEEF_0BAD_F00D; b = '1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin
      check({name, "_drain_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                     input logic [63:0] exp, input int lat, input string name);
    issue(o, x, y, exp, lat, name, 1'b1);
    drain(name);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", res, 64'd0);
    rstn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("idle_in_ready", 64'(in_ready), 64'd1);
      check("idle_out_valid", 64'(out_valid), 64'd0);
    end

    run(MULH,   MIN, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulh_min_x2");
    run(MULHU,  MIN, 64'd2, 64'd1, 65, "mulhu_min_x2");
    run(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulhsu_m1_x2");
    run(MUL,    64'd3, 64'd5, 64'd15, 65, "mul_3x5");
    run(MULW,   64'h0000_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw_sext");
    run(DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2");
    run(REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_m7_2");
    run(DIVU,   64'd100, 64'd7, 64'd14, 65, "divu_100_7");
    run(REMU,   64'd100, 64'd7, 64'd2, 65, "remu_100_7");
    run(DIVW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw_m7_2");
    run(REMW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw_m7_2");
    run(DIVU,   64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_by0");
    run(REM,    64'd5, 64'd0, 64'd5, 1, "rem_by0");
    run(DIV,    MIN, 64'hFFFF_FFFF_FFFF_FFFF, MIN, 1, "div_ovf");
    run(REM,    MIN, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_ovf");
    run(DIVUW,  64'd9, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divuw_by0");
    run(REMUW,  64'h1234_5678_8000_0001, 64'h0000_0005_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, "remuw_by0");
    run(DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
    run(4'b1001, 64'd6, 64'd7, 64'd0, 1, "illegal_1001");
    run(4'b1010, 64'd6, 64'd7, 64'd0, 1, "illegal_1010");

    // Backpressure: result held, no accept while DONE is stalled.
    out_ready = 1'b0;
    issue(MUL, 64'd6, 64'd7, 64'd42, 65, "bp_mul", 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    repeat (10) begin
      check("bp_res_stable", res, 64'd42);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid_high", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready", 64'(in_ready), 64'd1);
    check("bp_idle_out_valid", 64'(out_valid), 64'd0);
    drain("bp_mul");

    // Flush at BUSY cycle 20.
    issue(MUL, 64'd3, 64'd5, 64'd15, 65, "flushed", 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    check("flush_busy_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    op = MUL; a = 64'd2; b = 64'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    run(MUL, 64'd3, 64'd5, 64'd15, 65, "mul_after_flush");

    // Asynchronous reset in the middle of an operation.
    issue(MUL, 64'd6, 64'd7, 64'd42, 65, "reset_victim", 1'b0);
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_res", res, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    run(DIVU, 64'd100, 64'd7, 64'd14, 65, "divu_after_reset");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_mdu.md
# rv_mdu

Parametrised iterative multiply/divide unit: the execute-stage companion to the single-cycle integer ALU, implementing the RISC-V M-extension operations (including RV64 W-forms) over a valid/ready handshake. It computes one result bit per cycle with radix-2 shift-add multiplication and restoring division. Divide special cases and illegal ops finish early. The pipeline stalls on `in_ready` and drains on `out_valid`.

## Interface
- `XLEN`, default 64: operand/result width; legal values 32 and 64. W-ops are legal only when XLEN==64.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous abort of any in-flight or completed operation.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept a request; high only in IDLE.
- `op` input 4: operation code; see Operation.
- `a` input XLEN: rs1 operand.
- `b` input XLEN: rs2 operand.
- `out_valid` output 1: `res` is valid; high only in DONE.
- `out_ready` input 1: consumer accepts `res`.
- `res` output XLEN: result; held stable while `out_valid` is high and `out_ready` is low.

## Operation
- Opcodes:
  - 0000 MUL, 0001 MULH, 0010 MULHSU, 0011 MULHU.
  - 0100 DIV, 0101 DIVU, 0110 REM, 0111 REMU.
  - 1000 MULW, 1100 DIVW, 1101 DIVUW, 1110 REMW, 1111 REMUW.
  - All other codes are illegal. W-codes are also illegal when XLEN==32.
- Operation width W: 32 for W-ops, else XLEN. W-ops use only `a[31:0]` and `b[31:0]`; the 32-bit result is sign-extended to 64.
- Operands and inputs are latched at accept (`in_valid && in_ready`). Input changes after accept have no effect.
- Signed ops operate on magnitudes; the sign is fixed at the end.
  - Product sign = sign(a) XOR sign(b), with operands sign-qualified per op (MULHSU treats b as unsigned).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- MUL and MULW return the low W bits of the 2W-bit product. MULH, MULHSU and MULHU return the high XLEN bits.
- Divide special cases are detected at accept and go straight to DONE:
  - b==0: quotient = all ones; remainder = a (width W, sign-extended for W-ops).
  - Signed overflow (a = most-negative, b = -1): quotient = a; remainder = 0.
- Illegal op: res = 0, via the same early path.
- FSM states:
  - IDLE: `in_ready`=1. On accept, go to BUSY (normal) or DONE (early), and load the iteration counter with W.
  - BUSY: one shift-add or one restore-subtract step per cycle; counter decrements. When the counter reaches 1 and its step completes, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE. There is no back-to-back accept in the same cycle; `in_ready` stays low in DONE.
- `flush` has top priority in every state: the next state is IDLE, `out_valid` drops the next cycle, and the result is discarded. A request presented with `flush` high is not accepted.

## Timing
- Reset (`rstn` low, asynchronous):
  - State IDLE; `in_ready`=1; `out_valid`=0; `res`=0; counter=0.
  - Reset asserted mid-operation drops the operation immediately.
- Latency, with accept in cycle 0:
  - Normal op: BUSY occupies cycles 1..W, and `out_valid` first rises in cycle W+1. For XLEN=64 that is cycle 65 for DIV and cycle 33 for DIVW.
  - Early op: `out_valid` rises in cycle 1.
- Throughput: at most one op per W+2 cycles, since the unit returns to IDLE the cycle after the out handshake.
- `res` is registered and changes only on the DONE entry edge; a stall in DONE may last indefinitely.
- Final sign negation happens in the BUSY→DONE transition cycle; it adds no extra cycle.

## Test plan
- Reset then idle: `rstn` low asynchronously mid-cycle → `in_ready`=1, `out_valid`=0, `res`=0 immediately. Release `rstn` and hold `in_valid`=0 → unit stays IDLE.
- MULH, XLEN=64: a=0x8000_0000_0000_0000, b=2 → res=0xFFFF_FFFF_FFFF_FFFF at cycle 65. MULHU with the same operands → res=1.
- DIV, a=-7, b=2 → res=-3 at cycle 65; REM → res=-1. DIVW, a=0x0000_0000_FFFF_FFF9, b=2 → res=0xFFFF_FFFF_FFFF_FFFD at cycle 33.
- Early cases:
  - DIVU, b=0 → res=all ones at cycle 1.
  - REM, b=0, a=5 → res=5.
  - DIV, a=0x8000_0000_0000_0000, b=-1 → res=a, REM → 0, both at cycle 1.
  - Illegal op 1001 → res=0 at cycle 1.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `res` stable and `in_ready`=0 throughout. Raise `out_ready` → IDLE next cycle and `in_ready`=1.
- Flush: assert `flush` at BUSY cycle 20 → IDLE next cycle with `out_valid` never asserted. A new MUL 3×5 accepted afterwards → res=15 at cycle 65.
